branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Tournament branch predictor on the fetch side; it produces the prediction metadata (taken bit, 2-bit component prediction, local and global table indices) that the fetch/decode pipeline register carries forward.
- Also consumes that same metadata when it returns from the branch-resolution stage, and performs table training and global-history update.
- Lookup is combinational from the fetch PC. Update is a single-cycle write.
- After reset, an init walker clears all tables before predictions go live.

Parameters:
ls, 8, local index width; local PHT has 2^ls entries; ls >= gs required
gs, 6, global index width; global PHT, chooser and GHR are sized 2^gs / gs bits

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
pc_in  input  16  fetch PC (lc3b_word)
br_pr_out  output  1  final predicted-taken
pred_out  output  2  component predictions: [1]=local taken, [0]=global taken
local_index_out  output  ls  pc_in[ls:1]
global_index_out  output  gs  pc_in[gs:1] XOR ghr
init_busy  output  1  high while the init walker runs
upd_valid  input  1  resolved conditional branch this cycle
upd_taken  input  1  actual outcome
upd_pred  input  2  pred value carried down the pipe with the branch
upd_local_index  input  ls  carried local index
upd_global_index  input  gs  carried global index

Behaviour:
- Storage:
  - lpht: 2^ls x 2-bit saturating counters.
  - gpht: 2^gs x 2-bit saturating counters.
  - chooser: 2^gs x 2-bit counters; MSB=1 selects global.
  - ghr: gs bits.
- Reset (reset=0, async):
  - state <= INIT, init_ctr <= 0, ghr <= 0.
  - Outputs while reset is held or in INIT: br_pr_out=0, pred_out=2'b00, init_busy=1. Index outputs are still driven from pc_in/ghr.
- FSM, INIT:
  - Each cycle writes lpht[init_ctr]=2'b01.
  - If init_ctr < 2^gs, also writes gpht[init_ctr]=2'b01 and chooser[init_ctr]=2'b01.
  - init_ctr increments.
  - When init_ctr == 2^ls-1, the write completes and state -> RUN next cycle. INIT lasts exactly 2^ls cycles.
  - upd_valid is ignored in INIT: no table or ghr change.
- FSM, RUN: init_busy=0. Lookup and update are both active.
- Lookup (combinational, same cycle as pc_in):
  - li = pc_in[ls:1]; gi = pc_in[gs:1] ^ ghr.
  - pred_out = {lpht[li][1], gpht[gi][1]}.
  - br_pr_out = chooser[gi][1] ? pred_out[0] : pred_out[1].
- Update (RUN and upd_valid=1, committed at posedge):
  - lpht[upd_local_index] moves toward upd_taken, saturating at 00/11.
  - gpht[upd_global_index] is trained the same way.
  - Chooser is trained only if upd_pred[1] != upd_pred[0]:
    - increment (sat 11) if upd_pred[0]==upd_taken;
    - else decrement (sat 00).
  - ghr <= {ghr[gs-2:0], upd_taken} (non-speculative history).
- Training uses the carried indices, never recomputes them from the current ghr.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update value. The new value is visible the cycle after the edge.
- Reset asserted mid-INIT or mid-RUN: INIT restarts from 0. Table contents become don't-care until rewritten.
- Arrays have no reset. Only state, init_ctr and ghr are reset.

Test Plan:
- Reset release with ls=8 -> init_busy=1 for exactly 256 cycles, then 0; during INIT with upd_valid=1, upd_taken=1, ghr stays 0 and the outputs stay br_pr_out=0, pred_out=00.
- After init, pc_in=16'h0040, ghr=0 -> local_index_out=8'h20, global_index_out=6'h20, pred_out=00, br_pr_out=0.
- Two updates with upd_local_index=8'h20, upd_global_index=6'h20, upd_pred=00, upd_taken=1:
  - lpht/gpht go 01->10->11; ghr becomes 6'b000011;
  - chooser stays 01 because components agreed;
  - lookup with li=8'h20 gives pred_out[1]=1.
- Disagreement: upd_pred=2'b01 and upd_taken=1 on gi=5 -> chooser[5] 01->10, and a subsequent lookup mapping to gi=5 takes br_pr_out from the global bit; the same update repeated saturates the chooser at 11.
- Saturation: four upd_taken=0 updates on lpht[3] -> the counter holds at 00; the 5th update does not wrap.
- Same-cycle hazard: lookup index equals update index, counter 01, upd_taken=1 -> that cycle shows pred bit 0, the next cycle shows 1.
- Reset asserted in RUN while updates are streaming -> ghr=0 and init_busy=1 immediately, without waiting for a clock edge, then a full 256-cycle INIT.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for the tournament predictor.
// master: fetch/resolve logic driving pc and updates; slave: the predictor.
interface branch_predictor_if #(
  parameter int LS = 8,
  parameter int GS = 6
);
  logic [15:0]   pc_in;
  logic          br_pr_out;
  logic [1:0]    pred_out;
  logic [LS-1:0] local_index_out;
  logic [GS-1:0] global_index_out;
  logic          init_busy;
  logic          upd_valid;
  logic          upd_taken;
  logic [1:0]    upd_pred;
  logic [LS-1:0] upd_local_index;
  logic [GS-1:0] upd_global_index;

  modport master (
    output pc_in, upd_valid, upd_taken, upd_pred,
    output upd_local_index, upd_global_index,
    input  br_pr_out, pred_out, local_index_out,
    input  global_index_out, init_busy
  );

  modport slave (
    input  pc_in, upd_valid, upd_taken, upd_pred,
    input  upd_local_index, upd_global_index,
    output br_pr_out, pred_out, local_index_out,
    output global_index_out, init_busy
  );
endinterface

// File: rtl/branch_predictor.sv
// Tournament branch predictor: local/global 2-bit PHTs plus chooser.
// Ports: clk, reset (async active-low), bus (slave: lookup + update).
module branch_predictor #(
  parameter int ls = 8,
  parameter int gs = 6
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int LN = 2 ** ls;
  localparam int GN = 2 ** gs;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [ls-1:0] init_ctr, ctr_nx;
  logic [gs-1:0] ghr, ghr_nx;

  logic [1:0] lpht    [LN];
  logic [1:0] gpht    [GN];
  logic [1:0] chooser [GN];

  logic [ls-1:0] li;
  logic [gs-1:0] gi;
  logic          l_bit, g_bit, sel_g;

  logic          l_we, g_we, c_we;
  logic [ls-1:0] l_wa;
  logic [gs-1:0] g_wa, c_wa;
  logic [1:0]    l_wd, g_wd, c_wd;

  logic          br_pr, busy;
  logic [1:0]    pred;
  logic          init_g;
  logic          unused_pc;

  function automatic logic [1:0] sat(
    input logic [1:0] c,
    input logic       up
  );
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign li    = bus.pc_in[ls:1];
  assign gi    = bus.pc_in[gs:1] ^ ghr;
  assign l_bit = lpht[li][1];
  assign g_bit = gpht[gi][1];
  assign sel_g = chooser[gi][1];

  // init walker covers the smaller global tables only on its first GN steps
  assign init_g = int'(init_ctr) < GN;

  assign unused_pc = ^{bus.pc_in[15:ls+1], bus.pc_in[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_ctr <= '0;
      ghr      <= '0;
    end else begin
      state    <= state_nx;
      init_ctr <= ctr_nx;
      ghr      <= ghr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ctr_nx   = init_ctr;
    ghr_nx   = ghr;
    busy     = 1'b1;
    pred     = 2'b00;
    br_pr    = 1'b0;
    l_we     = 1'b0;
    g_we     = 1'b0;
    c_we     = 1'b0;
    l_wa     = bus.upd_local_index;
    g_wa     = bus.upd_global_index;
    c_wa     = bus.upd_global_index;
    l_wd     = sat(lpht[bus.upd_local_index], bus.upd_taken);
    g_wd     = sat(gpht[bus.upd_global_index], bus.upd_taken);
    c_wd     = sat(chooser[bus.upd_global_index],
                   bus.upd_pred[0] == bus.upd_taken);
    unique case (state)
      INIT: begin
        l_we   = 1'b1;
        l_wa   = init_ctr;
        l_wd   = 2'b01;
        g_we   = init_g;
        c_we   = init_g;
        g_wa   = init_ctr[gs-1:0];
        c_wa   = init_ctr[gs-1:0];
        g_wd   = 2'b01;
        c_wd   = 2'b01;
        ctr_nx = init_ctr + 1'b1;
        if (&init_ctr) state_nx = RUN;
      end
      RUN: begin
        busy  = 1'b0;
        pred  = {l_bit, g_bit};
        br_pr = sel_g ? g_bit : l_bit;
        if (bus.upd_valid) begin
          l_we   = 1'b1;
          g_we   = 1'b1;
          // chooser only learns when the components disagreed
          c_we   = bus.upd_pred[1] ^ bus.upd_pred[0];
          ghr_nx = {ghr[gs-2:0], bus.upd_taken};
        end
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (l_we) lpht[l_wa] <= l_wd;
    if (g_we) gpht[g_wa] <= g_wd;
    if (c_we) chooser[c_wa] <= c_wd;
  end

  assign bus.br_pr_out        = br_pr;
  assign bus.pred_out         = pred;
  assign bus.local_index_out  = li;
  assign bus.global_index_out = gi;
  assign bus.init_busy        = busy;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table model plus directed vectors.
// Drives at negedge+1, model commits at posedge, outputs checked at negedge.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.LS(8), .GS(6)) bus ();

  branch_predictor #(.ls(8), .gs(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int m_l [256];
  int m_g [64];
  int m_c [64];
  int m_ghr = 0;
  int m_cnt = 0;

  function automatic int msat(int c, bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0;
      m_ghr = 0;
    end else if (m_cnt < 256) begin
      m_l[m_cnt] = 1;
      if (m_cnt < 64) begin
        m_g[m_cnt] = 1;
        m_c[m_cnt] = 1;
      end
      m_cnt++;
    end else if (bus.upd_valid) begin
      m_l[int'(bus.upd_local_index)] =
        msat(m_l[int'(bus.upd_local_index)], bus.upd_taken);
      m_g[int'(bus.upd_global_index)] =
        msat(m_g[int'(bus.upd_global_index)], bus.upd_taken);
      if (bus.upd_pred[1] != bus.upd_pred[0])
        m_c[int'(bus.upd_global_index)] =
          msat(m_c[int'(bus.upd_global_index)],
               bus.upd_pred[0] == bus.upd_taken);
      m_ghr = ((m_ghr * 2) + int'(bus.upd_taken)) % 64;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int pc, li, gi, ep, eb;
      bit busy;
      pc   = int'(bus.pc_in);
      li   = (pc / 2) % 256;
      gi   = ((pc / 2) % 64) ^ m_ghr;
      busy = (m_cnt < 256) || !reset;
      ep   = 0;
      eb   = 0;
      if (!busy) begin
        ep = ((m_l[li] >= 2) ? 2 : 0) + ((m_g[gi] >= 2) ? 1 : 0);
        eb = (m_c[gi] >= 2) ? (ep % 2) : (ep / 2);
      end
      chk("cyc_busy", int'(bus.init_busy), int'(busy));
      chk("cyc_pred", int'(bus.pred_out), ep);
      chk("cyc_br", int'(bus.br_pr_out), eb);
      chk("cyc_li", int'(bus.local_index_out), li);
      chk("cyc_gi", int'(bus.global_index_out), gi);
    end
  end

  task automatic go();
    @(negedge clk);
    #1;
  endtask

  task automatic set_upd(bit v, int li, int gi, int p, bit t);
    bus.upd_valid        = v;
    bus.upd_local_index  = 8'(li);
    bus.upd_global_index = 6'(gi);
    bus.upd_pred         = 2'(p);
    bus.upd_taken        = t;
  endtask

  task automatic rnd_upd();
    set_upd(1'b1, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 63)),
            int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (bus.init_busy && n < 400) begin
      n++;
      go();
    end
  endtask

  initial begin
    int n;
    bus.pc_in = '0;
    set_upd(1'b0, 0, 0, 0, 1'b0);

    #1 reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", int'(bus.init_busy), 1);

    set_upd(1'b1, 0, 0, 0, 1'b1);
    repeat (3) go();
    chk("rst_hold_busy", int'(bus.init_busy), 1);
    chk("rst_hold_pred", int'(bus.pred_out), 0);
    chk("rst_hold_br", int'(bus.br_pr_out), 0);

    reset = 1'b1;
    wait_init(n);
    chk("init_len", n, 256);
    chk("init_ghr", int'(bus.global_index_out), 0);
    chk("init_pred", int'(bus.pred_out), 0);
    bus.upd_valid = 1'b0;

    bus.pc_in = 16'h0040;
    #1;
    chk("lk0_li", int'(bus.local_index_out), 'h20);
    chk("lk0_gi", int'(bus.global_index_out), 'h20);
    chk("lk0_pred", int'(bus.pred_out), 0);
    chk("lk0_br", int'(bus.br_pr_out), 0);

    set_upd(1'b1, 'h20, 'h20, 0, 1'b1);
    go();
    go();
    bus.upd_valid = 1'b0;
    #1;
    chk("agree_pred", int'(bus.pred_out), 2);
    chk("agree_br", int'(bus.br_pr_out), 1);
    chk("agree_gi", int'(bus.global_index_out), 'h23);
    bus.pc_in = 16'h0046;
    #1;
    chk("chooser_hold_pred", int'(bus.pred_out), 1);
    chk("chooser_hold_br", int'(bus.br_pr_out), 0);

    set_upd(1'b1, 'h50, 5, 1, 1'b1);
    go();
    bus.upd_valid = 1'b0;
    bus.pc_in = 16'h0004;
    #1;
    chk("dis_gi", int'(bus.global_index_out), 5);
    chk("dis_pred", int'(bus.pred_out), 1);
    chk("dis_br", int'(bus.br_pr_out), 1);
    bus.upd_valid = 1'b1;
    go();
    go();
    bus.upd_valid = 1'b0;
    bus.pc_in = 16'h0034;
    #1;
    chk("dis_sat_gi", int'(bus.global_index_out), 5);
    chk("dis_sat_br", int'(bus.br_pr_out), 1);

    set_upd(1'b1, 3, 'h3f, 3, 1'b0);
    repeat (5) go();
    bus.upd_valid = 1'b0;
    bus.pc_in = 16'h0006;
    #1;
    chk("sat_gi", int'(bus.global_index_out), 'h23);
    chk("sat_pred", int'(bus.pred_out), 0);
    chk("sat_br", int'(bus.br_pr_out), 0);

    bus.pc_in = 16'h0020;
    set_upd(1'b1, 'h10, 'h11, 3, 1'b1);
    #1;
    chk("haz_before", int'(bus.pred_out[1]), 0);
    go();
    bus.upd_valid = 1'b0;
    #1;
    chk("haz_after", int'(bus.pred_out[1]), 1);

    repeat (10) begin
      rnd_upd();
      go();
    end
    bus.pc_in = 16'h0020;
    reset = 1'b0;
    #1;
    chk("rerst_busy", int'(bus.init_busy), 1);
    chk("rerst_gi", int'(bus.global_index_out), 'h10);
    repeat (2) begin
      rnd_upd();
      go();
    end
    reset = 1'b1;
    wait_init(n);
    chk("reinit_len", n, 256);
    bus.upd_valid = 1'b0;
    bus.pc_in = 16'h0040;
    #1;
    chk("reinit_gi", int'(bus.global_index_out), 'h20);
    chk("reinit_pred", int'(bus.pred_out), 0);
    chk("reinit_br", int'(bus.br_pr_out), 0);

    repeat (300) begin
      bus.pc_in = 16'($urandom);
      rnd_upd();
      bus.upd_valid = 1'($urandom_range(0, 1));
      go();
    end
    bus.upd_valid = 1'b0;
    go();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
